// File: rtl/test_pipe_if.sv
// Bundles the sample input and the pipelined result outputs of test_pipe.
// The master drives samples; the slave (the pipe itself) produces results.
interface test_pipe_if #(
    parameter int I1_W  = 4,
    parameter int I2_W  = 2,
    parameter int O_W   = 8,
    parameter int CNT_W = 4
);
    logic             in_valid;
    logic [I1_W-1:0]  i1;
    logic [I2_W-1:0]  i2;
    logic             out_valid;
    logic [O_W-1:0]   o1;
    logic [O_W-1:0]   o2;
    logic [CNT_W-1:0] match_cnt;
    logic             trig;

    modport master (
        output in_valid, i1, i2,
        input  out_valid, o1, o2, match_cnt, trig
    );

    modport slave (
        input  in_valid, i1, i2,
        output out_valid, o1, o2, match_cnt, trig
    );
endinterface

// File: rtl/test_pipe.sv
// Masks the top of i1 with i2, pads the result into two words and delays them
// through a DEPTH-stage pipe; in parallel, counts matches and fires on a run.
module test_pipe #(
    parameter int                    I1_W     = 4,
    parameter int                    I2_W     = 2,
    parameter int                    O_W      = 8,
    parameter logic [O_W-I2_W-1:0]   PAD_A    = 6'b110011,
    parameter logic [O_W-I2_W-1:0]   PAD_B    = 6'b100111,
    parameter int                    DEPTH    = 2,
    parameter int                    CNT_W    = 4,
    parameter logic [I2_W-1:0]       TRIG_VAL = 2'b11,
    parameter int                    TRIG_LEN = 3
) (
    input  logic       clk,
    input  logic       reset,
    test_pipe_if.slave bus
);
    localparam int RUN_W = (TRIG_LEN < 2) ? 1 : $clog2(TRIG_LEN + 1);
    localparam logic [RUN_W-1:0] TRIG_LEN_R = RUN_W'(TRIG_LEN);

    typedef enum logic [1:0] {IDLE, RUN, FIRE} state_t;

    logic [I2_W-1:0]  internal;
    logic             accept;
    logic             is_match;
    logic [I2_W-1:0]  prev_reg;
    logic [CNT_W-1:0] match_cnt_reg;
    state_t           state_reg, state_next;
    logic [RUN_W-1:0] run_reg, run_next, run_inc;

    assign internal = bus.i1[I1_W-1 -: I2_W] & bus.i2;
    assign accept   = bus.in_valid;
    assign is_match = (internal == TRIG_VAL);
    assign run_inc  = run_reg + 1'b1;

    // Each stage loads only when a valid sample arrives, so the last stage
    // naturally holds the most recent output across bubbles.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic           vld_reg;
        logic [O_W-1:0] o1_reg;
        logic [O_W-1:0] o2_reg;
        logic           src_vld;
        logic [O_W-1:0] src_o1;
        logic [O_W-1:0] src_o2;

        if (gi == 0) begin : g_src
            assign src_vld = accept;
            assign src_o1  = {internal, PAD_A};
            assign src_o2  = {prev_reg, PAD_B};
        end else begin : g_src
            assign src_vld = g_stage[gi-1].vld_reg;
            assign src_o1  = g_stage[gi-1].o1_reg;
            assign src_o2  = g_stage[gi-1].o2_reg;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                vld_reg <= 1'b0;
                o1_reg  <= '0;
                o2_reg  <= '0;
            end else begin
                vld_reg <= src_vld;
                if (src_vld) begin
                    o1_reg <= src_o1;
                    o2_reg <= src_o2;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_reg      <= '0;
            match_cnt_reg <= '0;
            state_reg     <= IDLE;
            run_reg       <= '0;
        end else begin
            if (accept) begin
                prev_reg <= internal;
                if (is_match && (match_cnt_reg != '1)) begin
                    match_cnt_reg <= match_cnt_reg + 1'b1;
                end
            end
            state_reg <= state_next;
            run_reg   <= run_next;
        end
    end

    // Gaps (no acceptance) freeze the run; only FIRE leaves on its own.
    always_comb begin
        state_next = state_reg;
        run_next   = run_reg;
        case (state_reg)
            IDLE: begin
                if (accept && is_match) begin
                    if (TRIG_LEN == 1) begin
                        state_next = FIRE;
                    end else begin
                        state_next = RUN;
                        run_next   = RUN_W'(1);
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    if (is_match) begin
                        if (run_inc == TRIG_LEN_R) begin
                            state_next = FIRE;
                            run_next   = '0;
                        end else begin
                            run_next = run_inc;
                        end
                    end else begin
                        state_next = IDLE;
                        run_next   = '0;
                    end
                end
            end
            FIRE: begin
                run_next = '0;
                if (accept && is_match) begin
                    if (TRIG_LEN == 1) begin
                        state_next = FIRE;
                    end else begin
                        state_next = RUN;
                        run_next   = RUN_W'(1);
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                run_next   = '0;
            end
        endcase
    end

    assign bus.out_valid = g_stage[DEPTH-1].vld_reg;
    assign bus.o1        = g_stage[DEPTH-1].o1_reg;
    assign bus.o2        = g_stage[DEPTH-1].o2_reg;
    assign bus.match_cnt = match_cnt_reg;
    assign bus.trig      = (state_reg == FIRE);
endmodule

// File: tb/tb_test_pipe.sv
// Directed bench for test_pipe: an edge-log model predicts every output each
// cycle, and literal checks pin the key scenarios.
module tb_test_pipe;
    localparam int         DEPTH    = 2;
    localparam int         TRIG_LEN = 3;
    localparam logic [5:0] PAD_A    = 6'b110011;
    localparam logic [5:0] PAD_B    = 6'b100111;
    localparam logic [1:0] TRIG_VAL = 2'b11;
    localparam int         MAXE     = 1024;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    test_pipe_if #(.I1_W(4), .I2_W(2), .O_W(8), .CNT_W(4)) bus_if ();

    test_pipe dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int n_pass  = 0;
    int n_total = 0;
    bit check_en = 1'b0;

    // Model: a log of what happened at every edge, plus expected outputs.
    bit         log_acc [MAXE];
    bit         log_rst [MAXE];
    logic [7:0] log_o1  [MAXE];
    logic [7:0] log_o2  [MAXE];
    int         ecount   = 0;
    logic [1:0] m_prev   = 2'b00;
    int         m_cnt    = 0;
    int         m_streak = 0;
    logic       exp_valid = 1'b0;
    logic [7:0] exp_o1   = 8'h00;
    logic [7:0] exp_o2   = 8'h00;
    logic       exp_trig = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act !== req) begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end else begin
            n_pass++;
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("out_valid", 32'(bus_if.out_valid), 32'(exp_valid));
            chk("o1",        32'(bus_if.o1),        32'(exp_o1));
            chk("o2",        32'(bus_if.o2),        32'(exp_o2));
            chk("match_cnt", 32'(bus_if.match_cnt), 32'(m_cnt));
            chk("trig",      32'(bus_if.trig),      32'(exp_trig));
        end
    end

    task automatic model_edge(input bit rst, input bit v, input logic [3:0] a, input logic [1:0] b);
        logic [1:0] internal;
        int         e;
        int         src;
        bit         killed;
        e = ecount;
        internal   = a[3:2] & b;
        log_rst[e] = rst;
        log_acc[e] = !rst && v;
        log_o1[e]  = {internal, PAD_A};
        log_o2[e]  = {m_prev, PAD_B};
        exp_trig   = 1'b0;
        if (rst) begin
            m_prev = 2'b00; m_cnt = 0; m_streak = 0;
            exp_valid = 1'b0; exp_o1 = 8'h00; exp_o2 = 8'h00;
        end else begin
            if (v) begin
                m_prev = internal;
                if (internal == TRIG_VAL) begin
                    if (m_cnt < 15) m_cnt++;
                    m_streak++;
                    if (m_streak == TRIG_LEN) begin
                        exp_trig = 1'b1;
                        m_streak = 0;
                    end
                end else begin
                    m_streak = 0;
                end
            end
            src = e - (DEPTH - 1);
            killed = 1'b0;
            for (int k = src + 1; k <= e; k++) if (k >= 0 && log_rst[k]) killed = 1'b1;
            exp_valid = (src >= 0) && log_acc[src] && !killed;
            if (exp_valid) begin
                exp_o1 = log_o1[src];
                exp_o2 = log_o2[src];
            end
        end
        ecount++;
    endtask

    task automatic step(input bit rst, input bit v, input logic [3:0] a, input logic [1:0] b);
        reset           = rst;
        bus_if.in_valid = v;
        bus_if.i1       = a;
        bus_if.i2       = b;
        model_edge(rst, v, a, b);
        @(posedge clk);
        check_en = 1'b1;
        @(negedge clk);
        #1;
        $display("edge %0d rst=%0b v=%0b i1=%b i2=%b -> out_valid=%0b o1=%b o2=%b cnt=%0d trig=%0b",
                 ecount - 1, rst, v, a, b, bus_if.out_valid, bus_if.o1, bus_if.o2,
                 bus_if.match_cnt, bus_if.trig);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++)
            step(1'b1, 1'($urandom_range(0, 1)), 4'($urandom), 2'($urandom));
    endtask

    task automatic match();
        step(1'b0, 1'b1, 4'b1111, 2'b11);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'b0000, 2'b00);
    endtask

    initial begin
        reset = 1'b1;
        bus_if.in_valid = 1'b0;
        bus_if.i1 = '0;
        bus_if.i2 = '0;

        // Reset with random inputs
        do_reset(2);
        chk("rst out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("rst o1",        32'(bus_if.o1),        32'd0);
        chk("rst cnt",       32'(bus_if.match_cnt), 32'd0);
        chk("rst trig",      32'(bus_if.trig),      32'd0);

        // Single sample, latency DEPTH-1 edges, then hold
        step(1'b0, 1'b1, 4'b1100, 2'b10);
        chk("single lat0 valid", 32'(bus_if.out_valid), 32'd0);
        idle();
        chk("single valid", 32'(bus_if.out_valid), 32'd1);
        chk("single o1",    32'(bus_if.o1), 32'b10110011);
        chk("single o2",    32'(bus_if.o2), 32'b00100111);
        idle();
        chk("single bubble", 32'(bus_if.out_valid), 32'd0);
        chk("single hold o1", 32'(bus_if.o1), 32'b10110011);

        // Back-to-back samples
        do_reset(1);
        step(1'b0, 1'b1, 4'b1100, 2'b10);
        step(1'b0, 1'b1, 4'b1111, 2'b11);
        chk("b2b first valid", 32'(bus_if.out_valid), 32'd1);
        chk("b2b first o1",    32'(bus_if.o1), 32'b10110011);
        idle();
        chk("b2b second valid", 32'(bus_if.out_valid), 32'd1);
        chk("b2b second o1",    32'(bus_if.o1), 32'b11110011);
        chk("b2b second o2",    32'(bus_if.o2), 32'b10100111);
        idle();

        // Trigger across a gap
        do_reset(1);
        match(); match(); idle();
        chk("gap no trig", 32'(bus_if.trig), 32'd0);
        match();
        chk("gap trig", 32'(bus_if.trig), 32'd1);
        chk("gap cnt",  32'(bus_if.match_cnt), 32'd3);
        idle();
        chk("gap trig one cycle", 32'(bus_if.trig), 32'd0);

        // Broken run, then saturation
        do_reset(1);
        match(); match();
        step(1'b0, 1'b1, 4'b0000, 2'b11);
        match();
        chk("broken no trig", 32'(bus_if.trig), 32'd0);
        chk("broken cnt", 32'(bus_if.match_cnt), 32'd3);
        for (int i = 0; i < 20; i++) match();
        chk("sat cnt", 32'(bus_if.match_cnt), 32'd15);
        match();
        chk("sat held", 32'(bus_if.match_cnt), 32'd15);

        // Reset mid-run with a sample in flight
        do_reset(1);
        match(); match();
        do_reset(1);
        chk("midrst valid", 32'(bus_if.out_valid), 32'd0);
        idle();
        chk("midrst no flush", 32'(bus_if.out_valid), 32'd0);
        match(); match();
        chk("midrst two no trig", 32'(bus_if.trig), 32'd0);
        match();
        chk("midrst three trig", 32'(bus_if.trig), 32'd1);

        // Mixed traffic; the model judges each cycle
        for (int i = 0; i < 40; i++)
            step(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) != 0),
                 4'($urandom), 2'($urandom));
        idle(); idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
